// File: rtl/pht_pkg.sv
// Shared constants for the pattern history table predictor.
package pht_pkg;

  // Default history / index width; table depth is 2**HIST_W.
  localparam int unsigned HIST_W_DEF = 10;

  // 2-bit saturating counter encoding; direction is bit 1.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } pht_state_e;

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next value of a 2-bit saturating branch counter.
module sat_ctr2
  import pht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);

  // Step toward the outcome, holding at the strong ends.
  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != ST) next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/pht_predictor.sv
// Pattern history table of 2-bit counters indexed by local branch history.
// Registered fetch-side prediction, execute-side training, misprediction count.
module pht_predictor
  import pht_pkg::*;
#(
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter logic [1:0]  CTR_INIT = WT,
  parameter int unsigned MISS_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_valid,
  input  logic [HIST_W-1:0] lk_hist,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  output logic              ready,
  output logic [MISS_W-1:0] miss_cnt
);

  localparam int unsigned Depth = 2 ** HIST_W;

  pht_state_e        state_q, state_d;
  logic [HIST_W-1:0] idx_q, idx_d;
  logic [1:0]        table_q [Depth];

  logic              pred_valid_q, pred_taken_q;
  logic [MISS_W-1:0] miss_cnt_q;

  logic              sweep_we;
  logic              upd_en;
  logic [1:0]        upd_ctr, upd_next;
  logic [1:0]        lk_raw, lk_fwd, lk_ctr;
  logic              miss_inc;

  // FSM state and sweep index register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInit;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: leave the sweep on the edge that writes the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == StInit) begin
      idx_d = idx_q + HIST_W'(1);
      if (idx_q == '1) state_d = StRun;
    end
  end

  // FSM outputs: sweep write enable, ready, and gating of updates.
  always_comb begin
    sweep_we = (state_q == StInit);
    ready    = (state_q == StRun);
    upd_en   = upd_valid && (state_q == StRun);
  end

  assign upd_ctr = table_q[upd_hist];
  assign lk_raw  = table_q[lk_hist];

  sat_ctr2 u_upd_ctr (
    .ctr   (upd_ctr),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // Forwarding path: what the looked-up entry becomes if this cycle's update hits it.
  sat_ctr2 u_fwd_ctr (
    .ctr   (lk_raw),
    .taken (upd_taken),
    .next  (lk_fwd)
  );

  // Write-first: a same-index update is visible to the concurrent lookup.
  always_comb begin
    lk_ctr   = (upd_en && (upd_hist == lk_hist)) ? lk_fwd : lk_raw;
    miss_inc = upd_en && (upd_ctr[1] != upd_taken) && (miss_cnt_q != {MISS_W{1'b1}});
  end

  // Single table write port; reset leaves contents alone, the sweep initialises them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweep_we) begin
        table_q[idx_q] <= CTR_INIT;
      end else if (upd_en) begin
        table_q[upd_hist] <= upd_next;
      end
    end
  end

  // Registered prediction and saturating misprediction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      pred_valid_q <= lk_valid && ready;
      pred_taken_q <= lk_valid && ready && lk_ctr[1];
      if (miss_inc) miss_cnt_q <= miss_cnt_q + MISS_W'(1);
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Scoreboard bench for pht_predictor: lookups push expected directions, a monitor
// pops them whenever pred_valid is presented.
module tb_pht_predictor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lk_valid, upd_valid, upd_taken;
  logic [9:0] lk_hist, upd_hist;
  logic       pred_valid, pred_taken, ready;
  logic [15:0] miss_cnt;

  // Small instance for misprediction-counter saturation.
  logic       s_lk_valid, s_upd_valid, s_upd_taken;
  logic [2:0] s_lk_hist, s_upd_hist;
  logic       s_pred_valid, s_pred_taken, s_ready;
  logic [3:0] s_miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pht_predictor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (lk_valid),
    .lk_hist    (lk_hist),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_hist   (upd_hist),
    .upd_taken  (upd_taken),
    .ready      (ready),
    .miss_cnt   (miss_cnt)
  );

  pht_predictor #(.HIST_W(3), .CTR_INIT(2'b10), .MISS_W(4)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (s_lk_valid),
    .lk_hist    (s_lk_hist),
    .pred_valid (s_pred_valid),
    .pred_taken (s_pred_taken),
    .upd_valid  (s_upd_valid),
    .upd_hist   (s_upd_hist),
    .upd_taken  (s_upd_taken),
    .ready      (s_ready),
    .miss_cnt   (s_miss_cnt)
  );

  // Monitor: compare every presented prediction against the scoreboard head.
  always @(negedge clk) begin
    if (pred_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pred_unexpected: pred_valid=1 with no lookup outstanding (cycle %0d)", cyc);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (pred_taken !== e) begin
          n_bad++;
          $display("FAIL pred_taken: got %b expected %b (cycle %0d)", pred_taken, e, cyc);
        end
      end
    end else begin
      n_cmp++;
      if (pred_taken !== 1'b0) begin
        n_bad++;
        $display("FAIL pred_taken_idle: got %b expected 0 (cycle %0d)", pred_taken, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [9:0] h, input logic e);
    lk_valid = 1'b1;
    lk_hist  = h;
    exp_q.push_back(e);
    step();
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [9:0] h, input logic t);
    upd_valid = 1'b1;
    upd_hist  = h;
    upd_taken = t;
    step();
    upd_valid = 1'b0;
  endtask

  // Same-cycle update and lookup; e is the expected prediction.
  task automatic upd_lk(input logic [9:0] uh, input logic t, input logic [9:0] lh,
                        input logic e);
    upd_valid = 1'b1;
    upd_hist  = uh;
    upd_taken = t;
    lk_valid  = 1'b1;
    lk_hist   = lh;
    exp_q.push_back(e);
    step();
    upd_valid = 1'b0;
    lk_valid  = 1'b0;
  endtask

  // Release reset and sweep, driving traffic that must be ignored throughout.
  task automatic sweep_with_traffic();
    for (int i = 1; i <= 1024; i++) begin
      step();
      if (i == 1023) chk("ready_before_last", 32'(ready), 32'd0);
      if (i == 1024) begin
        chk("ready_after_sweep", 32'(ready), 32'd1);
        chk("miss_after_sweep", 32'(miss_cnt), 32'd0);
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
      end else begin
        lk_valid  = 1'b1;
        lk_hist   = 10'($urandom_range(0, 1023));
        upd_valid = 1'b1;
        upd_hist  = 10'($urandom_range(0, 1023));
        upd_taken = ~upd_taken;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lk_valid = 1'b0; lk_hist = '0;
    upd_valid = 1'b0; upd_hist = '0; upd_taken = 1'b0;
    s_lk_valid = 1'b0; s_lk_hist = '0;
    s_upd_valid = 1'b0; s_upd_hist = '0; s_upd_taken = 1'b0;

    repeat (3) step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);

    rst_n = 1'b1;
    sweep_with_traffic();

    // Every entry holds weakly taken after the sweep.
    for (int h = 0; h < 1024; h++) lookup(10'(h), 1'b1);

    // Small instance: alternate NT/T at one index; every update mispredicts.
    for (int k = 1; k <= 20; k++) begin
      s_upd_valid = 1'b1;
      s_upd_hist  = 3'd3;
      s_upd_taken = (k % 2 == 0);
      step();
      s_upd_valid = 1'b0;
      chk($sformatf("small_miss_%0d", k), 32'(s_miss_cnt), (k > 15) ? 32'd15 : 32'(k));
    end

    // hist 5: 10 -NT-> 01 -NT-> 00
    update(10'd5, 1'b0);
    update(10'd5, 1'b0);
    lookup(10'd5, 1'b0);
    chk("miss_h5_a", 32'(miss_cnt), 32'd1);
    // 00 -NT-> 00 -NT-> 00 -T-> 01
    update(10'd5, 1'b0);
    update(10'd5, 1'b0);
    update(10'd5, 1'b1);
    lookup(10'd5, 1'b0);
    chk("miss_h5_b", 32'(miss_cnt), 32'd2);

    // hist 7: 10 -T x4-> 11 -NT-> 10
    for (int k = 0; k < 4; k++) update(10'd7, 1'b1);
    chk("miss_h7_taken", 32'(miss_cnt), 32'd2);
    update(10'd7, 1'b0);
    lookup(10'd7, 1'b1);
    chk("miss_h7_nt", 32'(miss_cnt), 32'd3);

    // hist 9: 10 -NT-> 01, then NT with same-cycle lookup sees 00.
    update(10'd9, 1'b0);
    upd_lk(10'd9, 1'b0, 10'd9, 1'b0);
    chk("miss_h9", 32'(miss_cnt), 32'd4);

    // hist 11: lookup sees 01 only through forwarding (stored value is still 10).
    upd_lk(10'd11, 1'b0, 10'd11, 1'b0);
    // Different indices: lookup of 13 unaffected by update of 12.
    upd_lk(10'd12, 1'b0, 10'd13, 1'b1);
    lookup(10'd12, 1'b0);
    lookup(10'd11, 1'b0);
    chk("miss_fwd", 32'(miss_cnt), 32'd6);

    // Drive entries 0..31 to strongly not-taken before the mid-run reset.
    for (int h = 0; h < 32; h++) begin
      update(10'(h), 1'b0);
      update(10'(h), 1'b0);
    end
    lookup(10'd0, 1'b0);
    lookup(10'd31, 1'b0);

    while (cyc < 2000) step();
    rst_n    = 1'b0;
    lk_valid = 1'b1;
    lk_hist  = 10'd40;
    step();
    lk_valid = 1'b0;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_miss", 32'(miss_cnt), 32'd0);
    chk("midrst_pred_valid", 32'(pred_valid), 32'd0);
    chk("midrst_small_miss", 32'(s_miss_cnt), 32'd0);

    rst_n = 1'b1;
    sweep_with_traffic();
    for (int h = 0; h < 1024; h++) lookup(10'(h), 1'b1);

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pht_predictor.md
# pht_predictor

Second-level branch predictor: a pattern history table of 2-bit saturating counters indexed by the 10-bit local branch history produced by the local history table. Consumes the history on the fetch side to produce a registered taken/not-taken prediction, and consumes resolved branch outcomes on the execute side to train the counters. Sits between the local history table and the PC-select mux; also counts mispredictions for performance monitoring.

## Interface
- HIST_W, 10, history/index width; table depth is 2**HIST_W
- CTR_INIT, 2'b10, counter value written by the reset sweep (weakly taken)
- MISS_W, 16, width of the misprediction counter

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- lk_valid  input  1  lookup request this cycle
- lk_hist  input  HIST_W  history from the local history table for the fetching PC
- pred_valid  output  1  prediction valid (registered)
- pred_taken  output  1  predicted direction (registered)
- upd_valid  input  1  a conditional branch resolved this cycle
- upd_hist  input  HIST_W  history that was used to predict the resolved branch
- upd_taken  input  1  actual outcome (PCsel of the resolved branch)
- ready  output  1  table initialised; lookups and updates honoured
- miss_cnt  output  MISS_W  saturating count of resolved branches whose pre-update counter direction differed from upd_taken

## Operation
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken; direction = bit 1.
- FSM states: INIT, RUN.
- INIT: sweep index idx from 0 to 2**HIST_W-1, writing CTR_INIT to one entry per cycle; on writing the last entry go to RUN. ready=0; lookups produce pred_valid=0; updates dropped and not counted.
- RUN: ready=1.
  - Update: entry[upd_hist] <= taken ? min(ctr+1,3) : max(ctr-1,0). If ctr[1] != upd_taken and miss_cnt < 2**MISS_W-1, miss_cnt increments.
  - Lookup: pred_valid <= lk_valid; pred_taken <= direction of entry[lk_hist]. When lk_valid=0, pred_taken <= 0.
  - Same-cycle lookup and update at the same index: prediction uses the post-update counter value (write-first forwarding).
  - Same-cycle lookup and update at different indices: independent.
- Counters never wrap: 11 + taken stays 11, 00 + not-taken stays 00.
- miss_cnt saturates at all-ones; it is cleared only by reset.

## Timing
- While rst_n=0 at a rising edge: state=INIT, idx=0, pred_valid=0, pred_taken=0, ready=0, miss_cnt=0. Table contents are not touched by reset itself.
- Sweep: first entry written on the first edge with rst_n=1; ready rises after exactly 2**HIST_W edges with rst_n=1 (1024 for the default).
- Lookup latency: 1 cycle. Request at edge N yields pred_valid/pred_taken valid after edge N+1.
- Update takes effect at the edge it is sampled. A lookup of the same index in the next cycle sees the new value.
- ready drives 1 from the same edge that writes the last sweep entry's successor state, so a lookup presented in the first ready=1 cycle is honoured.
- Reset asserted mid-sweep or mid-run: restart the sweep from idx=0. The in-flight prediction is dropped (pred_valid=0).

## Structure
- Package pht_pkg: counter encoding constants (SNT, WNT, WT, ST), FSM state enum, default HIST_W.
- Sub-module sat_ctr2: combinational 2-bit saturating next-value (inputs ctr, taken; output next). It is instantiated twice: once for the update write and once for the forwarding path.
- Table is a plain register array of 2**HIST_W x 2 bits, with one read port for lookup, one read port for update, and one write port.

## Test plan
- Reset, then release: ready=0 for 1023 cycles and 1 on cycle 1024. The first lookups at hist 0, 511 and 1023 return pred_taken=1.
- Update hist=5 not-taken twice, then lookup 5: pred_taken=0. Two further not-taken updates followed by one taken update: lookup gives 0 (counter=01).
- Four taken updates on hist=7 followed by one not-taken update: lookup 7 gives 1 (counter=10). miss_cnt increments only on the not-taken update.
- Same cycle: upd_hist=9 not-taken twice in consecutive cycles, with lk_hist=9 during the second. pred_taken=0 next cycle, which demonstrates forwarding.
- Updates and lookups driven during the sweep: pred_valid stays 0 and miss_cnt stays 0. After ready, every entry still reads CTR_INIT.
- Drive rst_n=0 for one cycle at cycle 2000 after many updates: ready drops, miss_cnt=0, and after 1024 cycles all entries read weakly taken.
- Force 2**MISS_W mispredictions (use MISS_W=4): miss_cnt holds at 15.
